// File: rtl/spec_rat.sv
// spec_rat: speculative 4-wide register alias table with intra-group bypass and recovery reload
module spec_rat #(
  parameter int NUM_ARCH = 32,
  parameter int PREG_W = 7
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         inst0_vld_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst0_rs1_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst0_rs2_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst0_rd_i,
  input  logic                         inst0_rd_vld_i,
  output logic                         inst0_rd_req_o,
  input  logic [PREG_W-1:0]            inst0_freereg_i,
  input  logic                         inst0_freereg_vld_i,
  input  logic                         inst1_vld_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst1_rs1_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst1_rs2_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst1_rd_i,
  input  logic                         inst1_rd_vld_i,
  output logic                         inst1_rd_req_o,
  input  logic [PREG_W-1:0]            inst1_freereg_i,
  input  logic                         inst1_freereg_vld_i,
  input  logic                         inst2_vld_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst2_rs1_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst2_rs2_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst2_rd_i,
  input  logic                         inst2_rd_vld_i,
  output logic                         inst2_rd_req_o,
  input  logic [PREG_W-1:0]            inst2_freereg_i,
  input  logic                         inst2_freereg_vld_i,
  input  logic                         inst3_vld_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst3_rs1_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst3_rs2_i,
  input  logic [$clog2(NUM_ARCH)-1:0]  inst3_rd_i,
  input  logic                         inst3_rd_vld_i,
  output logic                         inst3_rd_req_o,
  input  logic [PREG_W-1:0]            inst3_freereg_i,
  input  logic                         inst3_freereg_vld_i,
  input  logic                         spec_rfl_stall_i,
  input  logic                         rename_stall_i,
  input  logic                         arch_rat_rec_i,
  input  logic [NUM_ARCH*PREG_W-1:0]   arch_rat_rec_data_i,
  output logic                         inst0_vld_o,
  output logic [PREG_W-1:0]            inst0_prs1_o,
  output logic [PREG_W-1:0]            inst0_prs2_o,
  output logic [PREG_W-1:0]            inst0_prd_o,
  output logic [PREG_W-1:0]            inst0_old_prd_o,
  output logic                         inst0_prd_vld_o,
  output logic                         inst1_vld_o,
  output logic [PREG_W-1:0]            inst1_prs1_o,
  output logic [PREG_W-1:0]            inst1_prs2_o,
  output logic [PREG_W-1:0]            inst1_prd_o,
  output logic [PREG_W-1:0]            inst1_old_prd_o,
  output logic                         inst1_prd_vld_o,
  output logic                         inst2_vld_o,
  output logic [PREG_W-1:0]            inst2_prs1_o,
  output logic [PREG_W-1:0]            inst2_prs2_o,
  output logic [PREG_W-1:0]            inst2_prd_o,
  output logic [PREG_W-1:0]            inst2_old_prd_o,
  output logic                         inst2_prd_vld_o,
  output logic                         inst3_vld_o,
  output logic [PREG_W-1:0]            inst3_prs1_o,
  output logic [PREG_W-1:0]            inst3_prs2_o,
  output logic [PREG_W-1:0]            inst3_prd_o,
  output logic [PREG_W-1:0]            inst3_old_prd_o,
  output logic                         inst3_prd_vld_o
);
  localparam int AW = $clog2(NUM_ARCH);
  localparam logic [AW-1:0] ZA = AW'(NUM_ARCH - 1);
  localparam logic [PREG_W-1:0] ZR = PREG_W'(NUM_ARCH - 1);

  logic [3:0] vld, rd_vld, fvld, req;
  logic [AW-1:0] rs1 [4];
  logic [AW-1:0] rs2 [4];
  logic [AW-1:0] rd [4];
  logic [PREG_W-1:0] fr [4];
  logic [PREG_W-1:0] map [NUM_ARCH];
  logic [PREG_W-1:0] map_nxt [NUM_ARCH];
  logic [PREG_W-1:0] p1 [4];
  logic [PREG_W-1:0] p2 [4];
  logic [PREG_W-1:0] pd [4];
  logic [PREG_W-1:0] po [4];
  logic [3:0] vld_q, prd_vld_q;
  logic [PREG_W-1:0] p1_q [4];
  logic [PREG_W-1:0] p2_q [4];
  logic [PREG_W-1:0] pd_q [4];
  logic [PREG_W-1:0] po_q [4];
  logic adv;
  logic unused_rec;

  assign vld = {inst3_vld_i, inst2_vld_i, inst1_vld_i, inst0_vld_i};
  assign rd_vld = {inst3_rd_vld_i, inst2_rd_vld_i, inst1_rd_vld_i, inst0_rd_vld_i};
  assign fvld = {inst3_freereg_vld_i, inst2_freereg_vld_i, inst1_freereg_vld_i, inst0_freereg_vld_i};
  assign rs1 = '{inst0_rs1_i, inst1_rs1_i, inst2_rs1_i, inst3_rs1_i};
  assign rs2 = '{inst0_rs2_i, inst1_rs2_i, inst2_rs2_i, inst3_rs2_i};
  assign rd = '{inst0_rd_i, inst1_rd_i, inst2_rd_i, inst3_rd_i};
  assign fr = '{inst0_freereg_i, inst1_freereg_i, inst2_freereg_i, inst3_freereg_i};

  // the zero register's recovery slice is deliberately dropped
  assign unused_rec = ^arch_rat_rec_data_i[NUM_ARCH*PREG_W-1 -: PREG_W];

  assign adv = ~rename_stall_i & ~spec_rfl_stall_i & ~arch_rat_rec_i;

  // rename request per slot; the zero register is never renamed
  always_comb begin
    for (int k = 0; k < 4; k++) req[k] = vld[k] & rd_vld[k] & (rd[k] != ZA);
  end

  assign inst0_rd_req_o = req[0];
  assign inst1_rd_req_o = req[1];
  assign inst2_rd_req_o = req[2];
  assign inst3_rd_req_o = req[3];

  // table lookup with bypass from the youngest older slot writing the same register
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      p1[k] = map[rs1[k]];
      p2[k] = map[rs2[k]];
      po[k] = map[rd[k]];
      pd[k] = req[k] ? fr[k] : ZR;
      for (int j = 0; j < k; j++) begin
        if (req[j] && rd[j] == rs1[k]) p1[k] = fr[j];
        if (req[j] && rd[j] == rs2[k]) p2[k] = fr[j];
        if (req[j] && rd[j] == rd[k]) po[k] = fr[j];
      end
    end
  end

  // next map: later slots overwrite earlier ones so the highest slot wins
  always_comb begin
    map_nxt = map;
    for (int k = 0; k < 4; k++) if (req[k] && fvld[k]) map_nxt[rd[k]] = fr[k];
  end

  // map table: identity on reset, recovery reload beats rename updates, entry 31 fixed
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ARCH; i++) map[i] <= PREG_W'(i);
    end else if (arch_rat_rec_i) begin
      for (int i = 0; i < NUM_ARCH - 1; i++) map[i] <= arch_rat_rec_data_i[i*PREG_W +: PREG_W];
      map[NUM_ARCH-1] <= ZR;
    end else if (adv) begin
      for (int i = 0; i < NUM_ARCH - 1; i++) map[i] <= map_nxt[i];
      map[NUM_ARCH-1] <= ZR;
    end
  end

  // dispatch register: recovery flushes, downstream stall holds, free-list stall bubbles
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q <= '0;
      prd_vld_q <= '0;
      for (int k = 0; k < 4; k++) begin
        p1_q[k] <= '0;
        p2_q[k] <= '0;
        pd_q[k] <= '0;
        po_q[k] <= '0;
      end
    end else if (arch_rat_rec_i) begin
      vld_q <= '0;
      prd_vld_q <= '0;
    end else if (!rename_stall_i) begin
      if (spec_rfl_stall_i) begin
        vld_q <= '0;
        prd_vld_q <= '0;
      end else begin
        vld_q <= vld;
        prd_vld_q <= req;
        p1_q <= p1;
        p2_q <= p2;
        pd_q <= pd;
        po_q <= po;
      end
    end
  end

  assign inst0_vld_o = vld_q[0];
  assign inst1_vld_o = vld_q[1];
  assign inst2_vld_o = vld_q[2];
  assign inst3_vld_o = vld_q[3];
  assign inst0_prd_vld_o = prd_vld_q[0];
  assign inst1_prd_vld_o = prd_vld_q[1];
  assign inst2_prd_vld_o = prd_vld_q[2];
  assign inst3_prd_vld_o = prd_vld_q[3];
  assign inst0_prs1_o = p1_q[0];
  assign inst1_prs1_o = p1_q[1];
  assign inst2_prs1_o = p1_q[2];
  assign inst3_prs1_o = p1_q[3];
  assign inst0_prs2_o = p2_q[0];
  assign inst1_prs2_o = p2_q[1];
  assign inst2_prs2_o = p2_q[2];
  assign inst3_prs2_o = p2_q[3];
  assign inst0_prd_o = pd_q[0];
  assign inst1_prd_o = pd_q[1];
  assign inst2_prd_o = pd_q[2];
  assign inst3_prd_o = pd_q[3];
  assign inst0_old_prd_o = po_q[0];
  assign inst1_old_prd_o = po_q[1];
  assign inst2_old_prd_o = po_q[2];
  assign inst3_old_prd_o = po_q[3];
endmodule

// File: tb/tb_spec_rat.sv
// tb_spec_rat: directed self-checking bench for spec_rat
module tb_spec_rat;
  logic clock = 1'b0;
  logic reset_n;
  logic vld [4];
  logic [4:0] rs1 [4];
  logic [4:0] rs2 [4];
  logic [4:0] rd [4];
  logic rd_vld [4];
  logic [6:0] fr [4];
  logic fvld [4];
  logic rfl_stall, ren_stall, rec;
  logic [223:0] rec_data;
  logic req_o [4];
  logic vld_o [4];
  logic [6:0] prs1_o [4];
  logic [6:0] prs2_o [4];
  logic [6:0] prd_o [4];
  logic [6:0] old_o [4];
  logic prdv_o [4];
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  spec_rat dut (
    .clock(clock), .reset_n(reset_n),
    .inst0_vld_i(vld[0]), .inst0_rs1_i(rs1[0]), .inst0_rs2_i(rs2[0]), .inst0_rd_i(rd[0]),
    .inst0_rd_vld_i(rd_vld[0]), .inst0_rd_req_o(req_o[0]), .inst0_freereg_i(fr[0]), .inst0_freereg_vld_i(fvld[0]),
    .inst1_vld_i(vld[1]), .inst1_rs1_i(rs1[1]), .inst1_rs2_i(rs2[1]), .inst1_rd_i(rd[1]),
    .inst1_rd_vld_i(rd_vld[1]), .inst1_rd_req_o(req_o[1]), .inst1_freereg_i(fr[1]), .inst1_freereg_vld_i(fvld[1]),
    .inst2_vld_i(vld[2]), .inst2_rs1_i(rs1[2]), .inst2_rs2_i(rs2[2]), .inst2_rd_i(rd[2]),
    .inst2_rd_vld_i(rd_vld[2]), .inst2_rd_req_o(req_o[2]), .inst2_freereg_i(fr[2]), .inst2_freereg_vld_i(fvld[2]),
    .inst3_vld_i(vld[3]), .inst3_rs1_i(rs1[3]), .inst3_rs2_i(rs2[3]), .inst3_rd_i(rd[3]),
    .inst3_rd_vld_i(rd_vld[3]), .inst3_rd_req_o(req_o[3]), .inst3_freereg_i(fr[3]), .inst3_freereg_vld_i(fvld[3]),
    .spec_rfl_stall_i(rfl_stall), .rename_stall_i(ren_stall),
    .arch_rat_rec_i(rec), .arch_rat_rec_data_i(rec_data),
    .inst0_vld_o(vld_o[0]), .inst0_prs1_o(prs1_o[0]), .inst0_prs2_o(prs2_o[0]),
    .inst0_prd_o(prd_o[0]), .inst0_old_prd_o(old_o[0]), .inst0_prd_vld_o(prdv_o[0]),
    .inst1_vld_o(vld_o[1]), .inst1_prs1_o(prs1_o[1]), .inst1_prs2_o(prs2_o[1]),
    .inst1_prd_o(prd_o[1]), .inst1_old_prd_o(old_o[1]), .inst1_prd_vld_o(prdv_o[1]),
    .inst2_vld_o(vld_o[2]), .inst2_prs1_o(prs1_o[2]), .inst2_prs2_o(prs2_o[2]),
    .inst2_prd_o(prd_o[2]), .inst2_old_prd_o(old_o[2]), .inst2_prd_vld_o(prdv_o[2]),
    .inst3_vld_o(vld_o[3]), .inst3_prs1_o(prs1_o[3]), .inst3_prs2_o(prs2_o[3]),
    .inst3_prd_o(prd_o[3]), .inst3_old_prd_o(old_o[3]), .inst3_prd_vld_o(prdv_o[3])
  );

  // a rename request without a valid free tag while the group advances is a protocol error
  always @(posedge clock) begin
    if (reset_n && !ren_stall && !rfl_stall && !rec)
      for (int k = 0; k < 4; k++)
        if (req_o[k] && !fvld[k]) begin
          bad++;
          $error("FAIL protocol slot%0d observed rd_req=1 freereg_vld=0 expected freereg_vld=1", k);
        end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int k = 0; k < 4; k++) begin
      vld[k] = 0; rs1[k] = 0; rs2[k] = 0; rd[k] = 0; rd_vld[k] = 0; fr[k] = 0; fvld[k] = 0;
    end
    rfl_stall = 0; ren_stall = 0; rec = 0;
  endtask

  task automatic slot(input int k, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                      input logic dv, input logic [6:0] f);
    vld[k] = 1; rs1[k] = a; rs2[k] = b; rd[k] = d; rd_vld[k] = dv; fr[k] = f; fvld[k] = dv;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ident();
    for (int i = 0; i < 32; i++) rec_data[7*i +: 7] = 7'(i);
  endtask

  initial begin
    clr();
    ident();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
    for (int k = 0; k < 4; k++) chk($sformatf("rst_vld%0d", k), 32'(vld_o[k]), 0);
    chk("rst_prdv0", 32'(prdv_o[0]), 0);
    chk("rst_prs1_0", 32'(prs1_o[0]), 0);
    chk("rst_prd0", 32'(prd_o[0]), 0);
    chk("rst_old3", 32'(old_o[3]), 0);
    // basic rename
    slot(0, 3, 4, 5, 1, 40);
    #1 chk("req0", 32'(req_o[0]), 1);
    step();
    chk("b_vld", 32'(vld_o[0]), 1);
    chk("b_prs1", 32'(prs1_o[0]), 3);
    chk("b_prs2", 32'(prs2_o[0]), 4);
    chk("b_prd", 32'(prd_o[0]), 40);
    chk("b_old", 32'(old_o[0]), 5);
    chk("b_prdv", 32'(prdv_o[0]), 1);
    clr();
    slot(0, 5, 6, 0, 0, 0);
    step();
    chk("lk_r5", 32'(prs1_o[0]), 40);
    chk("lk_r6", 32'(prs2_o[0]), 6);
    chk("norename_prd", 32'(prd_o[0]), 31);
    chk("norename_prdv", 32'(prdv_o[0]), 0);
    // intra-group dependencies
    clr();
    slot(0, 0, 0, 7, 1, 50);
    slot(2, 7, 1, 7, 1, 51);
    slot(3, 2, 7, 0, 0, 0);
    step();
    chk("g_old0", 32'(old_o[0]), 7);
    chk("g_vld1", 32'(vld_o[1]), 0);
    chk("g_prs1_2", 32'(prs1_o[2]), 50);
    chk("g_old2", 32'(old_o[2]), 50);
    chk("g_prd2", 32'(prd_o[2]), 51);
    chk("g_prs1_3", 32'(prs1_o[3]), 2);
    chk("g_prs2_3", 32'(prs2_o[3]), 51);
    clr();
    slot(1, 7, 7, 0, 0, 0);
    step();
    chk("lk_r7", 32'(prs1_o[1]), 51);
    // zero register
    clr();
    slot(0, 1, 2, 31, 1, 55);
    fvld[0] = 1;
    #1 chk("zr_req", 32'(req_o[0]), 0);
    step();
    chk("zr_prdv", 32'(prdv_o[0]), 0);
    chk("zr_prd", 32'(prd_o[0]), 31);
    clr();
    slot(0, 31, 31, 0, 0, 0);
    step();
    chk("lk_r31a", 32'(prs1_o[0]), 31);
    chk("lk_r31b", 32'(prs2_o[0]), 31);
    // downstream stall holds everything
    clr();
    slot(0, 3, 4, 9, 1, 61);
    step();
    chk("pre_stall_prd", 32'(prd_o[0]), 61);
    clr();
    slot(0, 10, 11, 10, 1, 62);
    ren_stall = 1;
    step();
    step();
    step();
    chk("st_vld", 32'(vld_o[0]), 1);
    chk("st_prs1", 32'(prs1_o[0]), 3);
    chk("st_prd", 32'(prd_o[0]), 61);
    clr();
    slot(0, 10, 9, 0, 0, 0);
    step();
    chk("st_lk_r10", 32'(prs1_o[0]), 10);
    chk("st_lk_r9", 32'(prs2_o[0]), 61);
    // free-list stall bubbles
    clr();
    slot(0, 1, 2, 11, 1, 63);
    rfl_stall = 1;
    step();
    chk("rfl_vld", 32'(vld_o[0]), 0);
    clr();
    slot(0, 11, 0, 0, 0, 0);
    step();
    chk("rfl_vld_back", 32'(vld_o[0]), 1);
    chk("rfl_lk_r11", 32'(prs1_o[0]), 11);
    // recovery
    clr();
    slot(0, 0, 0, 1, 1, 60);
    step();
    chk("r1_prd", 32'(prd_o[0]), 60);
    clr();
    slot(0, 1, 0, 0, 0, 0);
    step();
    chk("lk_r1_pre", 32'(prs1_o[0]), 60);
    clr();
    ident();
    rec_data[7*2 +: 7] = 70;
    rec_data[7*31 +: 7] = 5;
    slot(0, 0, 0, 12, 1, 64);
    slot(1, 0, 0, 13, 1, 65);
    rec = 1;
    step();
    for (int k = 0; k < 4; k++) chk($sformatf("rec_vld%0d", k), 32'(vld_o[k]), 0);
    chk("rec_prdv0", 32'(prdv_o[0]), 0);
    chk("rec_prdv1", 32'(prdv_o[1]), 0);
    clr();
    slot(0, 1, 2, 0, 0, 0);
    slot(1, 12, 31, 0, 0, 0);
    step();
    chk("rec_lk_r1", 32'(prs1_o[0]), 1);
    chk("rec_lk_r2", 32'(prs2_o[0]), 70);
    chk("rec_lk_r12", 32'(prs1_o[1]), 12);
    chk("rec_lk_r31", 32'(prs2_o[1]), 31);
    // recovery coincident with downstream stall
    clr();
    slot(0, 0, 0, 3, 1, 66);
    step();
    chk("rs_pre_vld", 32'(vld_o[0]), 1);
    clr();
    ident();
    rec_data[7*3 +: 7] = 71;
    rec_data[7*4 +: 7] = 72;
    rec = 1;
    ren_stall = 1;
    step();
    chk("rs_vld", 32'(vld_o[0]), 0);
    chk("rs_prdv", 32'(prdv_o[0]), 0);
    clr();
    slot(0, 3, 4, 0, 0, 0);
    step();
    chk("rs_lk_r3", 32'(prs1_o[0]), 71);
    chk("rs_lk_r4", 32'(prs2_o[0]), 72);
    // reset wins over a stall
    clr();
    ren_stall = 1;
    reset_n = 0;
    step();
    chk("rst_st_vld", 32'(vld_o[0]), 0);
    chk("rst_st_prs1", 32'(prs1_o[0]), 0);
    reset_n = 1;
    clr();
    slot(0, 3, 4, 0, 0, 0);
    step();
    chk("rst_lk_r3", 32'(prs1_o[0]), 3);
    chk("rst_lk_r4", 32'(prs2_o[0]), 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
